// File: rtl/led_seq_ctrl_if.sv
// Command port between the host-side decoder and the LED sequencer.
interface led_seq_ctrl_if #(
    parameter int unsigned DIV_W = 24
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_mode;
    logic [DIV_W-1:0] cmd_div;
    logic             cmd_err;

    modport master (
        output cmd_valid,
        output cmd_mode,
        output cmd_div,
        input  cmd_ready,
        input  cmd_err
    );

    modport slave (
        input  cmd_valid,
        input  cmd_mode,
        input  cmd_div,
        output cmd_ready,
        output cmd_err
    );
endinterface

// File: rtl/led_seq_ctrl.sv
// Command-driven sequencer for the 4-LED bank (active-low drive).
// A prescaler produces a step every div+1 cycles; each step advances the
// pattern for the current mode. Commands take one APPLY cycle to land.
module led_seq_ctrl #(
    parameter int unsigned      DIV_W       = 24,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = 24'd11_999_999
) (
    input  logic          iclk,
    input  logic          rst,
    led_seq_ctrl_if.slave cmd_if,
    output logic [3:0]    leds,
    output logic          step
);

    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_APPLY = 1'b1;

    localparam logic [2:0] M_HOLD    = 3'd0;
    localparam logic [2:0] M_ROT_L   = 3'd1;
    localparam logic [2:0] M_ROT_R   = 3'd2;
    localparam logic [2:0] M_BOUNCE  = 3'd3;
    localparam logic [2:0] M_BLINK   = 3'd4;
    localparam logic [2:0] M_ALL_OFF = 3'd5;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [0:0]       r_state;
    logic [3:0]       r_leds;
    logic [2:0]       r_mode;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic             r_dir;
    logic             r_step;
    logic             r_err;
    logic [2:0]       r_pmode;
    logic [DIV_W-1:0] r_pdiv;

    logic             w_xfer;
    logic             w_legal;
    logic             w_count_en;
    logic             w_tick;
    logic [3:0]       w_rot_l;
    logic [3:0]       w_rot_r;
    logic [3:0]       w_step_leds;
    logic             w_step_dir;
    logic [3:0]       w_keep_leds;
    logic [3:0]       w_load_leds;
    logic             w_load_dir;

    assign w_xfer  = cmd_if.cmd_valid && (r_state == S_RUN);
    assign w_legal = (r_pmode <= M_ALL_OFF);
    // A discarded command must not stall the prescaler, so APPLY counts too.
    assign w_count_en = (r_state == S_RUN) || !w_legal;
    assign w_tick     = w_count_en && (r_cnt == r_div);

    assign w_rot_l = {r_leds[2:0], r_leds[3]};
    assign w_rot_r = {r_leds[0], r_leds[3:1]};

    // Pattern and bounce direction after a prescaler step in the current mode.
    always_comb begin
        w_step_leds = r_leds;
        w_step_dir  = r_dir;
        case (r_mode)
            M_ROT_L:   w_step_leds = w_rot_l;
            M_ROT_R:   w_step_leds = w_rot_r;
            M_BOUNCE: begin
                if (r_dir == DIR_LEFT) begin
                    w_step_leds = w_rot_l;
                    if (w_rot_l == 4'b0111) w_step_dir = DIR_RIGHT;
                end else begin
                    w_step_leds = w_rot_r;
                    if (w_rot_r == 4'b1110) w_step_dir = DIR_LEFT;
                end
            end
            M_BLINK:   w_step_leds = ~r_leds;
            M_ALL_OFF: w_step_leds = 4'b1111;
            default:   ;
        endcase
    end

    // Pattern and direction loaded when a legal command is applied.
    always_comb begin
        w_keep_leds = $onehot(~r_leds) ? r_leds : 4'b1110;
        w_load_leds = r_leds;
        w_load_dir  = r_dir;
        case (r_pmode)
            M_ROT_L, M_ROT_R: w_load_leds = w_keep_leds;
            M_BOUNCE: begin
                w_load_leds = w_keep_leds;
                w_load_dir  = (w_keep_leds == 4'b0111) ? DIR_RIGHT : DIR_LEFT;
            end
            M_BLINK:   w_load_leds = 4'b0000;
            M_ALL_OFF: w_load_leds = 4'b1111;
            default:   ;
        endcase
    end

    // FSM, prescaler and pattern state; APPLY overrides a step taken in the same pass.
    always_ff @(posedge iclk or negedge rst) begin
        if (!rst) begin
            r_state <= S_RUN;
            r_leds  <= 4'b1110;
            r_mode  <= M_ROT_L;
            r_div   <= DEFAULT_DIV;
            r_cnt   <= '0;
            r_dir   <= DIR_LEFT;
            r_step  <= 1'b0;
            r_err   <= 1'b0;
            r_pmode <= M_HOLD;
            r_pdiv  <= '0;
        end else begin
            r_step <= w_tick;
            r_err  <= w_xfer && (cmd_if.cmd_mode > M_ALL_OFF);

            if (w_tick) begin
                r_cnt  <= '0;
                r_leds <= w_step_leds;
                r_dir  <= w_step_dir;
            end else if (w_count_en) begin
                r_cnt <= r_cnt + CNT_ONE;
            end

            case (r_state)
                S_RUN: begin
                    if (w_xfer) begin
                        r_state <= S_APPLY;
                        r_pmode <= cmd_if.cmd_mode;
                        r_pdiv  <= cmd_if.cmd_div;
                    end
                end
                default: begin
                    r_state <= S_RUN;
                    if (w_legal) begin
                        r_mode <= r_pmode;
                        r_div  <= r_pdiv;
                        r_cnt  <= '0;
                        r_leds <= w_load_leds;
                        r_dir  <= w_load_dir;
                    end
                end
            endcase
        end
    end

    assign cmd_if.cmd_ready = (r_state == S_RUN);
    assign cmd_if.cmd_err   = r_err;
    assign leds             = r_leds;
    assign step             = r_step;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl: directed vector table, hand-written reset
// sequence, then randomized commands against a behavioural model.
module tb_led_seq_ctrl;

    localparam int unsigned DIV_W = 24;

    logic       iclk;
    logic       rst;
    logic [3:0] leds;
    logic       step;

    led_seq_ctrl_if #(.DIV_W(DIV_W)) u_if ();

    led_seq_ctrl #(
        .DIV_W      (DIV_W),
        .DEFAULT_DIV(24'd3)
    ) u_dut (
        .iclk  (iclk),
        .rst   (rst),
        .cmd_if(u_if),
        .leds  (leds),
        .step  (step)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] e_leds, input logic e_step,
                           input logic e_ready, input logic e_err);
        chk({tag, " leds"}, leds, e_leds);
        chk({tag, " step"}, {3'b0, step}, {3'b0, e_step});
        chk({tag, " ready"}, {3'b0, u_if.cmd_ready}, {3'b0, e_ready});
        chk({tag, " err"}, {3'b0, u_if.cmd_err}, {3'b0, e_err});
    endtask

    // Directed vectors: inputs before an edge, outputs expected just after it.
    typedef struct {
        logic        v;
        logic [2:0]  mode;
        logic [23:0] div;
        logic [3:0]  leds;
        logic        step;
        logic        ready;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [2:0] mode, input logic [23:0] div,
                       input logic [3:0] l, input logic s, input logic r, input logic e);
        vec_t t;
        t.v = v; t.mode = mode; t.div = div; t.leds = l; t.step = s; t.ready = r; t.err = e;
        vecs.push_back(t);
    endtask

    // ---------------- behavioural reference model ----------------
    int         m_busy;
    logic [2:0] m_mode;
    logic [2:0] m_pmode;
    int         m_div;
    int         m_pdiv;
    int         m_left;
    logic [3:0] m_leds;
    int         m_bidx;
    logic       m_step;
    logic       m_err;
    int         bounce_tbl[6] = '{0, 1, 2, 3, 2, 1};

    function automatic logic [3:0] pat(input int p);
        logic [3:0] v;
        v = 4'b1111;
        v[p] = 1'b0;
        return v;
    endfunction

    function automatic int lit_pos(input logic [3:0] l);
        for (int i = 0; i < 4; i++) if (l[i] == 1'b0) return i;
        return 0;
    endfunction

    function automatic int zeros(input logic [3:0] l);
        int n = 0;
        for (int i = 0; i < 4; i++) if (l[i] == 1'b0) n++;
        return n;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_mode = 3'd1; m_pmode = 3'd0; m_div = 3; m_pdiv = 0; m_left = 3;
        m_leds = 4'b1110; m_bidx = 0; m_step = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_advance();
        case (m_mode)
            3'd1: m_leds = pat((lit_pos(m_leds) + 1) % 4);
            3'd2: m_leds = pat((lit_pos(m_leds) + 3) % 4);
            3'd3: begin
                m_bidx = (m_bidx + 1) % 6;
                m_leds = pat(bounce_tbl[m_bidx]);
            end
            3'd4: m_leds = ~m_leds;
            3'd5: m_leds = 4'b1111;
            default: ;
        endcase
    endtask

    // Countdown view of the prescaler: m_left cycles remain until the next step.
    task automatic model_prescale();
        if (m_left == 0) begin
            model_advance();
            m_left = m_div;
            m_step = 1'b1;
        end else begin
            m_left--;
        end
    endtask

    task automatic model_load();
        m_mode = m_pmode;
        m_div  = m_pdiv;
        m_left = m_pdiv;
        case (m_pmode)
            3'd1, 3'd2: if (zeros(m_leds) != 1) m_leds = 4'b1110;
            3'd3: begin
                if (zeros(m_leds) != 1) m_leds = 4'b1110;
                m_bidx = lit_pos(m_leds);
            end
            3'd4: m_leds = 4'b0000;
            3'd5: m_leds = 4'b1111;
            default: ;
        endcase
    endtask

    task automatic model_clock(input logic v, input logic [2:0] mode, input int div);
        m_step = 1'b0;
        m_err  = 1'b0;
        if (m_busy == 0) begin
            model_prescale();
            if (v) begin
                m_busy  = 1;
                m_pmode = mode;
                m_pdiv  = div;
                m_err   = (mode > 3'd5);
            end
        end else begin
            m_busy = 0;
            if (m_pmode > 3'd5) model_prescale();
            else model_load();
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        u_if.cmd_valid = 1'b0;
        u_if.cmd_mode  = 3'd0;
        u_if.cmd_div   = '0;

        // Rows 1-16: free-running ROT_L at div=3.
        for (int i = 1; i <= 16; i++) begin
            logic [3:0] l;
            case ((i) / 4)
                0: l = 4'b1110;
                1: l = 4'b1101;
                2: l = 4'b1011;
                3: l = 4'b0111;
                default: l = 4'b1110;
            endcase
            add(1'b0, 3'd0, 24'd0, l, (i % 4) == 0, 1'b1, 1'b0);
        end
        // Illegal mode: discarded, period kept.
        add(1'b1, 3'd7, 24'd5, 4'b1110, 1'b0, 1'b0, 1'b1);
        add(1'b0, 3'd0, 24'd0, 4'b1110, 1'b0, 1'b1, 1'b0);
        add(1'b0, 3'd0, 24'd0, 4'b1110, 1'b0, 1'b1, 1'b0);
        add(1'b0, 3'd0, 24'd0, 4'b1101, 1'b1, 1'b1, 1'b0);
        // ROT_R div=0 from 1101.
        add(1'b1, 3'd2, 24'd0, 4'b1101, 1'b0, 1'b0, 1'b0);
        add(1'b0, 3'd0, 24'd0, 4'b1101, 1'b0, 1'b1, 1'b0);
        add(1'b0, 3'd0, 24'd0, 4'b1110, 1'b1, 1'b1, 1'b0);
        add(1'b0, 3'd0, 24'd0, 4'b0111, 1'b1, 1'b1, 1'b0);
        add(1'b0, 3'd0, 24'd0, 4'b1011, 1'b1, 1'b1, 1'b0);
        // BLINK div=1; step due in the transfer cycle is taken.
        add(1'b1, 3'd4, 24'd1, 4'b1101, 1'b1, 1'b0, 1'b0);
        add(1'b0, 3'd0, 24'd0, 4'b0000, 1'b0, 1'b1, 1'b0);
        add(1'b0, 3'd0, 24'd0, 4'b0000, 1'b0, 1'b1, 1'b0);
        add(1'b0, 3'd0, 24'd0, 4'b1111, 1'b1, 1'b1, 1'b0);
        add(1'b0, 3'd0, 24'd0, 4'b1111, 1'b0, 1'b1, 1'b0);
        add(1'b0, 3'd0, 24'd0, 4'b0000, 1'b1, 1'b1, 1'b0);
        // ALL_OFF div=1.
        add(1'b1, 3'd5, 24'd1, 4'b0000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 3'd0, 24'd0, 4'b1111, 1'b0, 1'b1, 1'b0);
        add(1'b0, 3'd0, 24'd0, 4'b1111, 1'b0, 1'b1, 1'b0);
        add(1'b0, 3'd0, 24'd0, 4'b1111, 1'b1, 1'b1, 1'b0);
        add(1'b0, 3'd0, 24'd0, 4'b1111, 1'b0, 1'b1, 1'b0);
        add(1'b0, 3'd0, 24'd0, 4'b1111, 1'b1, 1'b1, 1'b0);
        // BOUNCE div=0 from a non-one-hot pattern: loads 1110.
        add(1'b1, 3'd3, 24'd0, 4'b1111, 1'b0, 1'b0, 1'b0);
        add(1'b0, 3'd0, 24'd0, 4'b1110, 1'b0, 1'b1, 1'b0);
        add(1'b0, 3'd0, 24'd0, 4'b1101, 1'b1, 1'b1, 1'b0);
        add(1'b0, 3'd0, 24'd0, 4'b1011, 1'b1, 1'b1, 1'b0);
        add(1'b0, 3'd0, 24'd0, 4'b0111, 1'b1, 1'b1, 1'b0);
        add(1'b0, 3'd0, 24'd0, 4'b1011, 1'b1, 1'b1, 1'b0);
        add(1'b0, 3'd0, 24'd0, 4'b1101, 1'b1, 1'b1, 1'b0);
        add(1'b0, 3'd0, 24'd0, 4'b1110, 1'b1, 1'b1, 1'b0);
        add(1'b0, 3'd0, 24'd0, 4'b1101, 1'b1, 1'b1, 1'b0);

        repeat (3) @(posedge iclk);
        #1;
        chk_all("reset", 4'b1110, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i + 1);
            u_if.cmd_valid = vecs[i].v;
            u_if.cmd_mode  = vecs[i].mode;
            u_if.cmd_div   = vecs[i].div;
            @(posedge iclk);
            #1;
            chk_all(tag, vecs[i].leds, vecs[i].step, vecs[i].ready, vecs[i].err);
        end

        // Reset asserted while an illegal command sits in APPLY.
        u_if.cmd_valid = 1'b1;
        u_if.cmd_mode  = 3'd6;
        u_if.cmd_div   = 24'd7;
        @(posedge iclk);
        #1;
        chk_all("pre-reset apply", 4'b1011, 1'b1, 1'b0, 1'b1);
        u_if.cmd_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk_all("async reset in apply", 4'b1110, 1'b0, 1'b1, 1'b0);
        #1 rst = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge iclk);
            #1;
            chk_all($sformatf("post-reset %0d", i), (i == 4) ? 4'b1101 : 4'b1110,
                    i == 4, 1'b1, 1'b0);
        end

        // Randomized commands against the model, with occasional mid-count resets.
        #2 rst = 1'b0;
        #1 rst = 1'b1;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic       v;
            logic [2:0] mode;
            int         div;
            v    = ($urandom_range(0, 3) == 0);
            mode = 3'($urandom_range(0, 7));
            div  = $urandom_range(0, 3);
            u_if.cmd_valid = v;
            u_if.cmd_mode  = mode;
            u_if.cmd_div   = 24'(div);
            @(posedge iclk);
            #1;
            model_clock(v, mode, div);
            chk_all($sformatf("rand%0d", c), m_leds, m_step, (m_busy == 0), m_err);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b0;
                #1;
                model_reset();
                chk_all($sformatf("rand reset%0d", c), m_leds, m_step, 1'b1, m_err);
                #1 rst = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
